// File: rtl/pim_pkg.sv
// Shared helpers for the PIM pipeline stages: sizing function, default widths and
// the shift/ReLU/saturate requantizer.
package pim_pkg;

  localparam int NIB_DEF   = 4;
  localparam int ADC_P_DEF = 4;

  // Number of bits needed to index `value` entries.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Arithmetic right shift, optional clamp of negatives, then saturate to out_p bits.
  function automatic logic [31:0] sat_shift(input logic signed [31:0] value,
                                            input int                 shift,
                                            input bit                 relu,
                                            input int                 out_p);
    logic signed [31:0] s;
    logic signed [31:0] max_v;
    s     = value >>> shift;
    max_v = (32'sd1 <<< out_p) - 32'sd1;
    if (relu && s < 0) s = '0;
    if (s > max_v) s = max_v;
    return s;
  endfunction

endpackage

// File: rtl/pim_out_fifo.sv
// Two-entry first-word-fall-through queue; the head entry is visible on pop_data
// whenever the queue is not empty.
module pim_out_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage is reset because its head drives out_data, which must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pim_shift_acc.sv
// Bit-serial shift-accumulate: weights the four ADC partial sums of each bit-plane,
// accumulates NIB planes, requantizes and queues the result with its column tag.
module pim_shift_acc
  import pim_pkg::*;
#(
  parameter  int ADC_P     = ADC_P_DEF,
  parameter  int NIB       = NIB_DEF,
  parameter  int DEPTH     = 32,
  parameter  int ACC_W     = 20,
  parameter  int OUT_P     = 8,
  parameter  int OUT_SHIFT = 8,
  parameter  int RELU      = 1,
  localparam int AW        = clogb2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADC_P-1:0] in_hh,
  input  logic [ADC_P-1:0] in_hl,
  input  logic [ADC_P-1:0] in_lh,
  input  logic [ADC_P-1:0] in_ll,
  input  logic [AW-1:0]    in_addr,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_P-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             proto_err
);

  localparam int            BW        = (NIB > 1) ? clogb2(NIB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NIB - 1);

  logic [BW-1:0]       beat;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    contrib;
  logic [ACC_W-1:0]    final_sum;
  logic [AW-1:0]       tag;
  logic [AW-1:0]       push_addr;
  logic [OUT_P-1:0]    result;
  logic [OUT_P+AW-1:0] head;
  logic                beat_fire;
  logic                is_final;
  logic                early_last;
  logic                missing_last;
  logic                push;
  logic                full;
  logic                empty;

  assign beat_fire    = in_valid & in_ready;
  assign is_final     = (beat == LAST_BEAT);
  assign early_last   = beat_fire & in_last & ~is_final;
  assign missing_last = beat_fire & ~in_last & is_final;
  assign push         = beat_fire & is_final;
  assign push_addr    = (beat == '0) ? in_addr : tag;

  // Beat 0 starts from zero so a previous or aborted sum never leaks in.
  always_comb begin
    int sh_b;
    sh_b      = int'(beat);
    contrib   = (ACC_W'(in_hh) << (sh_b + 2 * NIB))
              + ((ACC_W'(in_hl) + ACC_W'(in_lh)) << (sh_b + NIB))
              + (ACC_W'(in_ll) << sh_b);
    final_sum = ((beat == '0) ? '0 : acc) + contrib;
  end

  assign result = OUT_P'(sat_shift(32'(signed'(final_sum)), OUT_SHIFT, RELU != 0, OUT_P));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      acc       <= '0;
      tag       <= '0;
      proto_err <= 1'b0;
    end else begin
      if (early_last | missing_last) proto_err <= 1'b1;
      if (beat_fire) begin
        acc <= final_sum;
        if (beat == '0) tag <= in_addr;
        beat <= (is_final || in_last) ? '0 : beat + 1'b1;
      end
    end
  end

  pim_out_fifo #(
    .W (OUT_P + AW)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({result, push_addr}),
    .pop       (out_valid & out_ready),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_data  = head[OUT_P+AW-1:AW];
  assign out_addr  = head[AW-1:0];

endmodule

// File: tb/tb_pim_shift_acc.sv
// Self-checking bench: three instances (OUT_SHIFT 0, 2, 8) share the input stream and
// are checked against a queue-based arithmetic model of the shift-accumulate stage.
module tb_pim_shift_acc;

  localparam int NDUT = 3;

  typedef struct {
    int unsigned sum;
    logic [4:0]  addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_hh, in_hl, in_lh, in_ll;
  logic [4:0] in_addr;
  logic       in_last;
  logic       out_ready;
  logic       rdy  [NDUT];
  logic       vld  [NDUT];
  logic [7:0] data [NDUT];
  logic [4:0] addr [NDUT];
  logic       perr [NDUT];

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rand_ready = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int SH = (g == 0) ? 0 : (g == 1) ? 2 : 8;
    pim_shift_acc #(.OUT_SHIFT(SH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .in_hh     (in_hh),
      .in_hl     (in_hl),
      .in_lh     (in_lh),
      .in_ll     (in_ll),
      .in_addr   (in_addr),
      .in_last   (in_last),
      .out_valid (vld[g]),
      .out_ready (out_ready),
      .out_data  (data[g]),
      .out_addr  (addr[g]),
      .proto_err (perr[g])
    );
  end

  function automatic int shift_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 8;
  endfunction

  function automatic int unsigned requant(input int unsigned sum, input int sh);
    int unsigned r;
    r = sum >> sh;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("spurious_output", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("out_valid_s%0d", shift_of(k)), vld[k], 1);
      check($sformatf("out_data_s%0d", shift_of(k)), data[k], requant(e.sum, shift_of(k)));
      check($sformatf("out_addr_s%0d", shift_of(k)), addr[k], e.addr);
    end
  endtask

  // One clock: sample/consume at the falling edge, return just after the rising edge.
  task automatic step(output bit accepted);
    @(negedge clk);
    accepted = in_valid && rdy[0];
    if (vld[0] === 1'b1 && out_ready) pop_check();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [3:0] hh, hl, lh, ll, input logic [4:0] a, input bit last);
    bit ok;
    ok       = 1'b0;
    in_hh    = hh;
    in_hl    = hl;
    in_lh    = lh;
    in_ll    = ll;
    in_addr  = a;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) step(ok);
    check("beat_accepted", ok, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Beat b uses nibble b of each vector; abort_at >= 0 raises in_last early on that beat.
  task automatic send_result(input logic [15:0] hh_v, hl_v, lh_v, ll_v, input logic [4:0] a,
                             input int abort_at, input bit drop_last);
    int unsigned sum;
    sum = 0;
    for (int b = 0; b < 4; b++) begin
      bit last;
      last = (b == abort_at) || (b == 3 && !drop_last);
      send_beat(hh_v[4*b +: 4], hl_v[4*b +: 4], lh_v[4*b +: 4], ll_v[4*b +: 4], a, last);
      if (b == abort_at) return;
      sum += (int'(hh_v[4*b +: 4]) * 256 + (int'(hl_v[4*b +: 4]) + int'(lh_v[4*b +: 4])) * 16
              + int'(ll_v[4*b +: 4])) * (1 << b);
    end
    exp_q.push_back('{sum: sum, addr: a});
  endtask

  task automatic idle(input int n);
    bit d;
    for (int i = 0; i < n; i++) step(d);
  endtask

  task automatic drain();
    bit d;
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) step(d);
    check("drained", exp_q.size(), 0);
    check("empty_after_drain", vld[0], 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2;
    for (int k = 0; k < NDUT; k++) begin
      check("rst_in_ready", rdy[k], 1);
      check("rst_out_valid", vld[k], 0);
      check("rst_out_data", data[k], 0);
      check("rst_out_addr", addr[k], 0);
      check("rst_proto_err", perr[k], 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    {in_hh, in_hl, in_lh, in_ll} = '0;
    in_addr   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single result, all ones: sum 4335, visible one cycle after the last beat.
    send_result(16'h1111, 16'h1111, 16'h1111, 16'h1111, 5'd5, -1, 1'b0);
    check("t1_latency_valid", vld[0], 1);
    check("t1_data_s0", data[0], 255);
    check("t1_data_s2", data[1], 255);
    check("t1_data_s8", data[2], 16);
    check("t1_addr", addr[0], 5);
    drain();

    // Only ll = 1: sum 15.
    send_result(16'h0, 16'h0, 16'h0, 16'h1111, 5'd9, -1, 1'b0);
    check("t2_data_s0", data[0], 15);
    check("t2_data_s2", data[1], 3);
    check("t2_data_s8", data[2], 0);
    drain();

    // Backpressure: two results fill the queue, the third waits for the consumer.
    out_ready = 1'b0;
    send_result(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 5'd1, -1, 1'b0);
    check("bp_ready_after_one", rdy[0], 1);
    send_result(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 5'd2, -1, 1'b0);
    check("bp_ready_drops", rdy[0], 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("bp_ready_held_low", rdy[0], 0);
      check("bp_head_data_stable", data[0], requant(exp_q[0].sum, 0));
      check("bp_head_addr_stable", addr[0], exp_q[0].addr);
    end
    out_ready = 1'b1;
    send_result(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 5'd3, -1, 1'b0);
    drain();

    // Early in_last on beat 1: flagged, nothing queued, next clean result is correct.
    send_result(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 5'd7, 1, 1'b0);
    check("pe_flag", perr[0], 1);
    idle(4);
    check("pe_no_output", vld[0], 0);
    send_result(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 5'd8, -1, 1'b0);
    drain();
    check("pe_sticky", perr[0], 1);

    // Reset with one result queued and two beats of another in flight.
    out_ready = 1'b0;
    send_result(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 5'd4, -1, 1'b0);
    send_beat(4'hf, 4'hf, 4'hf, 4'hf, 5'd6, 1'b0);
    send_beat(4'hf, 4'hf, 4'hf, 4'hf, 5'd6, 1'b0);
    do_reset();
    out_ready = 1'b1;
    send_result(16'h1111, 16'h1111, 16'h1111, 16'h1111, 5'd5, -1, 1'b0);
    check("rst_rerun_data_s0", data[0], 255);
    check("rst_rerun_data_s8", data[2], 16);
    check("rst_rerun_addr", addr[0], 5);
    drain();

    // Missing in_last on the final beat: flagged, result still delivered.
    send_result(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 5'd12, -1, 1'b1);
    check("ml_flag", perr[0], 1);
    drain();

    // Random traffic with random consumer stalls.
    do_reset();
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      send_result(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  5'($urandom), -1, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();
    check("rand_no_proto_err", perr[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
